// File: rtl/seq_array_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_array_divider_if
// Description : Request/result bundle for the sequential restoring divider.
//               The master side issues operands with start; the slave side
//               (the divider) returns busy/done and the held results.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_array_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    // Requester: drives operands, observes status and results
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider: samples operands, drives status and results
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_array_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_array_divider
// Description : Iterative restoring divider, one quotient bit per clock.
//               DW-bit dividend / VW-bit divisor -> DW-bit quotient and
//               VW-bit remainder. A zero divisor short-cuts to a fixed
//               result (all-ones quotient, low dividend bits as remainder)
//               flagged by div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_array_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    seq_array_divider_if.slave div_if
);
    // Iteration counter width: must hold DW-1
    localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]   quo_q;       // shifts dividend out at the top, quotient bits in at the bottom
    logic [VW-1:0]   rem_q;       // partial remainder; always < divisor between steps
    logic [VW-1:0]   divisor_q;
    logic            dz_q;        // current run had a zero divisor

    logic            busy_q;
    logic            done_q;
    logic [DW-1:0]   quotient_q;
    logic [VW-1:0]   remainder_q;
    logic            div_by_zero_q;

    // One restoring step. The shifted partial remainder needs VW+1 bits
    // before the compare; after a successful subtract the difference is
    // below the divisor, so the subtraction only needs the low VW bits.
    logic [VW:0]     rem_shift_d;
    logic [VW-1:0]   rem_sub_d;
    logic            fits_d;
    logic [VW-1:0]   rem_d;
    logic [DW-1:0]   quo_d;

    // Combinational shift / compare / conditional subtract for the RUN state
    always_comb begin
        rem_shift_d = {rem_q, quo_q[DW-1]};
        fits_d      = (rem_shift_d >= {1'b0, divisor_q});
        rem_sub_d   = rem_shift_d[VW-1:0] - divisor_q;
        rem_d       = fits_d ? rem_sub_d : rem_shift_d[VW-1:0];
        quo_d       = {quo_q[DW-2:0], fits_d};
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            divisor_q     <= '0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (div_if.start) begin
                        quo_q     <= div_if.dividend;
                        divisor_q <= div_if.divisor;
                        rem_q     <= '0;
                        cnt_q     <= CNT_W'(DW - 1);
                        busy_q    <= 1'b1;
                        if (div_if.divisor == '0) begin
                            dz_q    <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIN: begin
                    // Zero divisor: quo_q still holds the untouched dividend
                    quotient_q    <= dz_q ? {DW{1'b1}} : quo_q;
                    remainder_q   <= dz_q ? quo_q[VW-1:0] : rem_q;
                    div_by_zero_q <= dz_q;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;
    assign div_if.div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_array_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_array_divider
// Description : Self-checking bench for seq_array_divider. A cycle-level
//               behavioural model (plain / and %, a latency countdown) is
//               compared against the DUT every cycle; directed cases pin
//               literal results, then an exhaustive sweep, a multiplier
//               feedback loop and randomized traffic follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_array_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_array_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_array_divider #(.DW(DW), .VW(VW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy, m_done, m_dz;
    int m_q, m_r, m_left;
    int p_q, p_r;
    bit p_dz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_q = 0; m_r = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_q = p_q; m_r = p_r; m_dz = p_dz;
                end
            end else if (bus.start) begin
                m_busy = 1;
                if (bus.divisor == 0) begin
                    p_q = (1 << DW) - 1;
                    p_r = int'(bus.dividend) % (1 << VW);
                    p_dz = 1;
                    m_left = 1;
                end else begin
                    p_q = int'(bus.dividend) / int'(bus.divisor);
                    p_r = int'(bus.dividend) % int'(bus.divisor);
                    p_dz = 0;
                    m_left = DW + 1;
                end
            end
        end
    end

    // Compare process: outputs are always meaningful (held between dones)
    always @(negedge clk) begin
        chk("busy",        bus.busy,        64'(m_busy));
        chk("done",        bus.done,        64'(m_done));
        chk("quotient",    bus.quotient,    64'(m_q));
        chk("remainder",   bus.remainder,   64'(m_r));
        chk("div_by_zero", bus.div_by_zero, 64'(m_dz));
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = VW'($urandom);
    endtask

    task automatic wait_done(output int edges);
        bit got;
        got = 0;
        edges = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done) got = 1;
        end
        if (!got) chk("done_timeout", 64'(got), 64'd1);
    endtask

    task automatic divide(input logic [DW-1:0] a, input logic [VW-1:0] b, output int edges);
        issue(a, b);
        wait_done(edges);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, n;
        logic [DW-1:0] a;
        logic [VW-1:0] b;

        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", bus.busy, 64'd0);
        chk("reset_done", bus.done, 64'd0);
        chk("reset_q",    bus.quotient, 64'd0);
        chk("reset_r",    bus.remainder, 64'd0);
        chk("reset_dz",   bus.div_by_zero, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // 1: 0xDD / 0xD
        divide(8'hDD, 4'hD, e);
        chk("t1_latency", 64'(e), 64'd9);
        chk("t1_q", bus.quotient, 64'h11);
        chk("t1_r", bus.remainder, 64'h0);
        chk("t1_dz", bus.div_by_zero, 64'd0);
        chk("t1_busy", bus.busy, 64'd0);
        chk("t1_model_q", 64'(m_q), 64'h11);

        // 2: assorted patterns
        divide(8'hFF, 4'h1, e);
        chk("t2a_q", bus.quotient, 64'hFF);
        chk("t2a_r", bus.remainder, 64'h0);
        divide(8'h64, 4'h7, e);
        chk("t2b_q", bus.quotient, 64'h0E);
        chk("t2b_r", bus.remainder, 64'h2);
        chk("t2b_model_r", 64'(m_r), 64'h2);
        divide(8'h00, 4'h5, e);
        chk("t2c_q", bus.quotient, 64'h0);
        chk("t2c_r", bus.remainder, 64'h0);

        // 3: divide by zero, then a valid divide clears the flag
        divide(8'h5A, 4'h0, e);
        chk("t3_latency", 64'(e), 64'd1);
        chk("t3_q", bus.quotient, 64'hFF);
        chk("t3_r", bus.remainder, 64'hA);
        chk("t3_dz", bus.div_by_zero, 64'd1);
        chk("t3_model_dz", 64'(m_dz), 64'd1);
        divide(8'h20, 4'h3, e);
        chk("t3_clear_q", bus.quotient, 64'h0A);
        chk("t3_clear_r", bus.remainder, 64'h2);
        chk("t3_clear_dz", bus.div_by_zero, 64'd0);

        // 4: reset mid-division clears everything, no late done
        divide(8'h3B, 4'h0, e);
        issue(8'hC8, 4'h7);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t4_busy", bus.busy, 64'd0);
        chk("t4_done", bus.done, 64'd0);
        chk("t4_q", bus.quotient, 64'd0);
        chk("t4_r", bus.remainder, 64'd0);
        chk("t4_dz", bus.div_by_zero, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        count_dones(15, n);
        chk("t4_no_done", 64'(n), 64'd0);
        @(posedge clk); #2;

        // 5: back-to-back start on the done cycle, start while busy ignored
        divide(8'h41, 4'h6, e);
        chk("t5a_q", bus.quotient, 64'h0A);
        chk("t5a_r", bus.remainder, 64'h5);
        issue(8'h90, 4'h9);
        @(posedge clk); #2;
        bus.start = 1'b1; bus.dividend = 8'h11; bus.divisor = 4'h2;
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done(e);
        chk("t5_latency", 64'(e), 64'd7);
        chk("t5_q", bus.quotient, 64'h10);
        chk("t5_r", bus.remainder, 64'h0);
        count_dones(12, n);
        chk("t5_ignored", 64'(n), 64'd0);

        // 6: exhaustive sweep of nonzero divisors
        for (int i = 0; i < 256; i++) begin
            for (int j = 1; j < 16; j++) begin
                divide(DW'(i), VW'(j), e);
                chk("sweep_identity", 64'(int'(bus.quotient) * j + int'(bus.remainder)), 64'(i));
                chk("sweep_rem_lt", 64'(int'(bus.remainder) < j), 64'd1);
            end
        end

        // Multiplier feedback: (x*y)/y == x exactly
        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                divide(DW'(x * y), VW'(y), e);
                chk("mulfb_q", bus.quotient, 64'(x));
                chk("mulfb_r", bus.remainder, 64'd0);
            end
        end

        // Randomized traffic: gaps, zero divisors, stray starts while busy
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
            a = DW'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom_range(1, 15));
            issue(a, b);
            if (b != 0 && $urandom_range(0, 1) == 1) begin
                bus.start = 1'b1;
                @(posedge clk); #2;
                bus.start = 1'b0;
            end
            wait_done(e);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
